decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, width of the saturating stall counter.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_valid  in  1  fetch presents an instruction.
REQ-005 SHALL have port if_ready  out  1  decode accepts the instruction this cycle.
REQ-006 SHALL have ports if_pc, if_instr  in  32 each  fetched PC and instruction word.
REQ-007 SHALL have port flush  in  1  squash the held instruction and refuse input (branch/jump redirect).
REQ-008 SHALL have port ex_valid  out  1  output register holds a decoded instruction.
REQ-009 SHALL have port ex_ready  in  1  execute consumes the output register this cycle.
REQ-010 SHALL have ports ex_pc, ex_instr  out  32 each  registered PC and instruction.
REQ-011 SHALL have port ex_ctrl  out  rv32i_control_word  registered control word.
REQ-012 SHALL have ports ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices.
REQ-013 SHALL have port ex_imm  out  32  registered, sign-extended immediate.
REQ-014 SHALL have port ex_illegal  out  1  registered; the held opcode is not a defined rv32i_opcode.
REQ-015 SHALL have ports instr_count  out  32 and stall_count  out  STALL_CNT_W  performance counters.

Function
REQ-016 SHALL implement a single output register: load on (if_valid & if_ready); ex_valid cleared when ex_ready & !(if_valid & if_ready).
REQ-017 SHALL drive if_ready = !flush & !hazard & (!ex_valid | ex_ready), combinationally.
REQ-018 SHALL assert hazard when ex_valid, ex_ctrl.opcode = op_load, ex_rd != 0, and the incoming instruction reads ex_rd (rs1 for jalr/br/load/store/imm/reg; rs2 for br/store/reg).
REQ-019 SHALL, when hazard & ex_ready & !flush, clear ex_valid (one bubble); the stalled instruction is accepted the following cycle, giving exactly one bubble per load-use.
REQ-020 SHALL, on flush, clear ex_valid at the next edge regardless of ex_ready; flush dominates accept and hazard.
REQ-021 SHALL hold all ex_* outputs stable while ex_valid & !ex_ready & !flush.
REQ-022 SHALL decode immediates: I/jalr/load/imm = instr[31:20] sext; S = {instr[31:25],instr[11:7]} sext; B = {instr[31],instr[7],instr[30:25],instr[11:8],0} sext; U = {instr[31:12],12'b0}; J = {instr[31],instr[19:12],instr[20],instr[30:21],0} sext; others 0.
REQ-023 SHALL set load_regfile for lui/auipc/jal/jalr/load/imm/reg only when rd != 0.
REQ-024 SHALL set data_read and load_data_address for load; data_write, load_data_address and load_data_out for store; load_data_value for load.
REQ-025 SHALL map aluop from funct3 (add, sll, xor, or, and, srl); instr[30] selects alu_sub for op_reg add and alu_sra for sr (both reg and imm).
REQ-026 SHALL set cmpop = funct3 for op_br, blt for slt/slti, bltu for sltu/sltiu, beq otherwise.
REQ-027 SHALL select alumux1 = PC for auipc/jal/br, rs1 otherwise; alumux2 = immediate except op_reg (rs2).
REQ-028 SHALL, for illegal opcode, zero all load/read/write enables in ex_ctrl and set ex_illegal; instruction still passes the handshake.
REQ-029 SHALL increment instr_count (wrapping modulo 2^32) on each accept.
REQ-030 SHALL increment stall_count on each hazard bubble cycle (REQ-019), saturating at all-ones.

Reset
REQ-031 SHALL, on rst_n low, immediately clear ex_valid, ex_illegal, ex_pc, ex_instr, ex_ctrl, ex_rs1/rs2/rd, ex_imm, instr_count, stall_count to 0.
REQ-032 SHALL, with rst_n low and flush low, present if_ready = 1; no accept occurs until first edge after rst_n rises.
REQ-033 SHALL, when reset asserts mid-stall, discard the held instruction; no bubble or count is recorded.

Verification
REQ-034 Reset: rst_n=0 asynchronously mid-cycle -> ex_valid=0, counters 0, if_ready=1 immediately.
REQ-035 Decode: if_instr=0x00500093 (addi x1,x0,5), ex_ready=1 -> next cycle ex_valid=1, ex_rd=1, ex_imm=5, aluop=alu_add, load_regfile=1, instr_count=1.
REQ-036 Load-use: 0x0000A103 (lw x2,0(x1)) then 0x002101B3 (add x3,x2,x2) -> one bubble cycle with ex_valid=0, add issued one cycle later, stall_count=1; with rd=x0 instead -> no bubble.
REQ-037 Backpressure: ex_ready=0 for 3 cycles with if_valid=1 -> if_ready=0, ex_* unchanged, instr_count unchanged.
REQ-038 Flush: flush=1 with if_valid=1, ex_valid=1 -> if_ready=0, next cycle ex_valid=0, input not consumed.
REQ-039 Illegal/saturation: if_instr opcode 0x7F -> ex_illegal=1, all enables 0; stall_count forced to all-ones then another hazard -> stays all-ones.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: one output register with valid/ready handshake,
// load-use bubble insertion, flush, and accept/stall performance counters.
package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef struct packed {
    rv32i_opcode    opcode;
    alu_ops         aluop;
    branch_funct3_t cmpop;
    logic           alumux1_sel;
    logic           alumux2_sel;
    logic           load_regfile;
    logic           data_read;
    logic           data_write;
    logic           load_data_address;
    logic           load_data_out;
    logic           load_data_value;
  } rv32i_control_word;
endpackage

module decode_stage
  import rv32i_types::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [31:0]            if_pc,
  input  logic [31:0]            if_instr,
  input  logic                   flush,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [31:0]            ex_pc,
  output logic [31:0]            ex_instr,
  output rv32i_control_word      ex_ctrl,
  output logic [4:0]             ex_rs1,
  output logic [4:0]             ex_rs2,
  output logic [4:0]             ex_rd,
  output logic [31:0]            ex_imm,
  output logic                   ex_illegal,
  output logic [31:0]            instr_count,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic                   r_valid;
  logic [31:0]            r_pc;
  logic [31:0]            r_instr;
  rv32i_control_word      r_ctrl;
  logic [4:0]             r_rs1;
  logic [4:0]             r_rs2;
  logic [4:0]             r_rd;
  logic [31:0]            r_imm;
  logic                   r_illegal;
  logic [31:0]            r_icnt;
  logic [STALL_CNT_W-1:0] r_stall;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;
  logic w_lui, w_auipc, w_jal, w_jalr, w_br;
  logic w_load, w_store, w_opimm, w_opreg;
  logic w_use1, w_use2, w_wr_rd;
  logic w_hazard, w_accept, w_bubble, w_legal;
  rv32i_control_word w_ctrl;
  logic [31:0] w_imm;
  alu_ops w_alu;

  assign w_op  = if_instr[6:0];
  assign w_f3  = if_instr[14:12];
  assign w_rs1 = if_instr[19:15];
  assign w_rs2 = if_instr[24:20];
  assign w_rd  = if_instr[11:7];

  assign w_lui   = (w_op == op_lui);
  assign w_auipc = (w_op == op_auipc);
  assign w_jal   = (w_op == op_jal);
  assign w_jalr  = (w_op == op_jalr);
  assign w_br    = (w_op == op_br);
  assign w_load  = (w_op == op_load);
  assign w_store = (w_op == op_store);
  assign w_opimm = (w_op == op_imm);
  assign w_opreg = (w_op == op_reg);

  assign w_use1  = w_jalr | w_br | w_load | w_store | w_opimm | w_opreg;
  assign w_use2  = w_br | w_store | w_opreg;
  assign w_wr_rd = (w_rd != 5'd0);

  always_comb begin
    w_alu = alu_ops'(w_f3);
    if (w_f3 == 3'b101 && if_instr[30])
      w_alu = alu_sra;
    if (w_opreg && w_f3 == 3'b000 && if_instr[30])
      w_alu = alu_sub;
  end

  always_comb begin
    w_ctrl        = '0;
    w_ctrl.opcode = rv32i_opcode'(w_op);
    w_ctrl.aluop  = alu_add;
    w_ctrl.cmpop  = beq;
    w_imm         = '0;
    w_legal       = 1'b1;
    unique case (1'b1)
      w_lui, w_auipc: begin
        w_imm = {if_instr[31:12], 12'b0};
        w_ctrl.alumux1_sel  = w_auipc;
        w_ctrl.load_regfile = w_wr_rd;
      end
      w_jal: begin
        w_imm = {{12{if_instr[31]}}, if_instr[19:12],
                 if_instr[20], if_instr[30:21], 1'b0};
        w_ctrl.alumux1_sel  = 1'b1;
        w_ctrl.load_regfile = w_wr_rd;
      end
      w_jalr: begin
        w_imm = {{20{if_instr[31]}}, if_instr[31:20]};
        w_ctrl.load_regfile = w_wr_rd;
      end
      w_br: begin
        w_imm = {{20{if_instr[31]}}, if_instr[7],
                 if_instr[30:25], if_instr[11:8], 1'b0};
        w_ctrl.alumux1_sel = 1'b1;
        w_ctrl.cmpop = branch_funct3_t'(w_f3);
      end
      w_load: begin
        w_imm = {{20{if_instr[31]}}, if_instr[31:20]};
        w_ctrl.load_regfile      = w_wr_rd;
        w_ctrl.data_read         = 1'b1;
        w_ctrl.load_data_address = 1'b1;
        w_ctrl.load_data_value   = 1'b1;
      end
      w_store: begin
        w_imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        w_ctrl.data_write        = 1'b1;
        w_ctrl.load_data_address = 1'b1;
        w_ctrl.load_data_out     = 1'b1;
      end
      w_opimm, w_opreg: begin
        if (w_opimm)
          w_imm = {{20{if_instr[31]}}, if_instr[31:20]};
        w_ctrl.alumux2_sel  = w_opreg;
        w_ctrl.load_regfile = w_wr_rd;
        w_ctrl.aluop        = w_alu;
        if (w_f3 == 3'b010)
          w_ctrl.cmpop = blt;
        else if (w_f3 == 3'b011)
          w_ctrl.cmpop = bltu;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Only a held load whose result the incoming instruction needs forces a stall.
  assign w_hazard = if_valid & r_valid & (r_ctrl.opcode == op_load)
                  & (r_rd != 5'd0)
                  & ((w_use1 & (w_rs1 == r_rd)) | (w_use2 & (w_rs2 == r_rd)));

  assign if_ready = ~flush & ~w_hazard & (~r_valid | ex_ready);
  assign w_accept = if_valid & if_ready;
  assign w_bubble = w_hazard & ex_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_instr   <= '0;
      r_ctrl    <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
      r_icnt    <= '0;
      r_stall   <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid   <= 1'b1;
        r_pc      <= if_pc;
        r_instr   <= if_instr;
        r_ctrl    <= w_ctrl;
        r_rs1     <= w_rs1;
        r_rs2     <= w_rs2;
        r_rd      <= w_rd;
        r_imm     <= w_imm;
        r_illegal <= ~w_legal;
      end else if (ex_ready) begin
        r_valid <= 1'b0;
      end
      if (w_accept)
        r_icnt <= r_icnt + 32'd1;
      if (w_bubble && r_stall != '1)
        r_stall <= r_stall + STALL_CNT_W'(1);
    end
  end

  assign ex_valid    = r_valid;
  assign ex_pc       = r_pc;
  assign ex_instr    = r_instr;
  assign ex_ctrl     = r_ctrl;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_rd       = r_rd;
  assign ex_imm      = r_imm;
  assign ex_illegal  = r_illegal;
  assign instr_count = r_icnt;
  assign stall_count = r_stall;

endmodule
